// File: rtl/reg_file_dump.sv
// Debug access engine for the integer register file: either streams every register
// out over a valid/ready port, or clears x1..x31 through the write port.
module reg_file_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_mode,
  input  logic              abort,
  input  logic              port_gnt,
  output logic [ADDR_W-1:0] rd_reg,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMP,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              issued_q, issued_d;
  logic              dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0] dout_data_q, dout_data_d;
  logic [ADDR_W-1:0] dout_idx_q, dout_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic active;
  logic load;
  logic hshake;

  assign active = (state_q != S_IDLE);
  // The output register refills when it is empty or its word leaves this cycle.
  assign load   = (state_q == S_DUMP) && port_gnt && !issued_q && !abort &&
                  (!dout_valid_q || dout_ready);
  assign hshake = dout_valid_q && dout_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    issued_d     = issued_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_idx_d   = dout_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issued_d = 1'b0;
          if (clear_mode) begin
            state_d = S_CLEAR;
            idx_d   = ADDR_W'(1);
          end else begin
            state_d = S_DUMP;
            idx_d   = '0;
          end
        end
      end
      S_DUMP: begin
        if (load) begin
          dout_data_d  = rd_data;
          dout_idx_d   = idx_q;
          dout_valid_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            issued_d = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end else if (hshake) begin
          dout_valid_d = 1'b0;
        end
        if (hshake && (dout_idx_q == LAST_IDX)) begin
          state_d = S_DONE;
        end
      end
      S_CLEAR: begin
        if (port_gnt) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && active) begin
      state_d      = S_IDLE;
      dout_valid_d = 1'b0;
    end
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      issued_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      issued_q     <= issued_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_idx_q   <= dout_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_reg     = idx_q;
  assign wr_reg     = idx_q;
  assign wr_data    = '0;
  assign wr_en      = (state_q == S_CLEAR) && port_gnt && !abort;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_idx   = dout_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: a table of dump/clear scenarios run against a
// simple register-file model, plus hand-written reset and abort sequences.
module tb_reg_file_dump;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clear_mode;
  logic              abort;
  logic              port_gnt;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_idx;
  logic              busy;
  logic              done;

  reg_file_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear_mode(clear_mode),
    .abort     (abort),
    .port_gnt  (port_gnt),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data (dout_data),
    .dout_idx  (dout_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file model: x0 reads as zero; loadKind 1 = 0xA5A50000+i, 2 = all ones.
  logic [DATA_W-1:0] mem [NUM_REGS];
  int                loadKind = 0;

  always @(posedge clk) begin
    if (loadKind != 0) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= (loadKind == 1) ? DATA_W'(32'hA5A5_0000 + i) : '1;
    end else if (wr_en && (wr_reg != '0)) begin
      mem[wr_reg] <= wr_data;
    end
  end

  assign rd_data = (rd_reg == '0) ? '0 : mem[rd_reg];

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic preload(input int kind);
    @(negedge clk);
    loadKind = kind;
    @(negedge clk);
    loadKind = 0;
  endtask

  typedef struct {
    string name;
    bit    clearMode;
    int    preloadKind;
    int    gntPeriod;
    bit    readyToggle;
    bit    pokeStart;
    bit    expZero;
    int    expCycles;
  } vec_t;

  vec_t vecs [6];

  task automatic applyStimulus(input vec_t v);
    int words = 0, idxErr = 0, dataErr = 0, stallErr = 0;
    int writes = 0, x0Writes = 0, wrOrderErr = 0;
    int donePulses = 0, doneAt = 0, nextIdx = 0, nextWr = 1, k = 0;
    bit prevStall = 1'b0;
    logic [DATA_W-1:0] prevData = '0;
    logic [ADDR_W-1:0] prevIdx = '0;
    logic [DATA_W-1:0] expData;

    if (v.preloadKind != 0) preload(v.preloadKind);
    @(negedge clk);
    start      = 1'b1;
    clear_mode = v.clearMode;
    port_gnt   = 1'b1;
    dout_ready = 1'b1;
    while (k < 600) begin
      @(negedge clk);
      k++;
      start      = 1'b0;
      clear_mode = v.clearMode;
      if (v.pokeStart && (k >= 5) && (k <= 8)) begin
        start      = 1'b1;
        clear_mode = (k % 2 == 1);
      end
      if (prevStall && (!dout_valid || dout_data != prevData || dout_idx != prevIdx))
        stallErr++;
      if (done) begin
        donePulses++;
        if (doneAt == 0) doneAt = k;
      end
      if (!busy) break;
      port_gnt   = (v.gntPeriod == 0) || (k % v.gntPeriod != 0);
      dout_ready = !v.readyToggle || (k % 2 == 1);
      #1;
      if (dout_valid && dout_ready) begin
        if (dout_idx != ADDR_W'(nextIdx)) idxErr++;
        expData = (v.expZero || dout_idx == '0) ? '0 : DATA_W'(32'hA5A5_0000 + int'(dout_idx));
        if (dout_data != expData) dataErr++;
        words++;
        nextIdx++;
      end
      prevStall = dout_valid && !dout_ready;
      prevData  = dout_data;
      prevIdx   = dout_idx;
      if (wr_en) begin
        writes++;
        if (wr_reg == '0) x0Writes++;
        if (wr_reg != ADDR_W'(nextWr)) wrOrderErr++;
        nextWr++;
      end
    end
    start      = 1'b0;
    clear_mode = 1'b0;
    port_gnt   = 1'b1;
    dout_ready = 1'b1;

    checkOutput({v.name, " busy_at_end"}, 32'(busy), 32'd0);
    checkOutput({v.name, " words"}, words, v.clearMode ? 0 : NUM_REGS);
    checkOutput({v.name, " idx_order_errs"}, idxErr, 0);
    checkOutput({v.name, " data_errs"}, dataErr, 0);
    checkOutput({v.name, " stall_errs"}, stallErr, 0);
    checkOutput({v.name, " writes"}, writes, v.clearMode ? NUM_REGS - 1 : 0);
    checkOutput({v.name, " x0_writes"}, x0Writes, 0);
    checkOutput({v.name, " wr_order_errs"}, wrOrderErr, 0);
    checkOutput({v.name, " done_pulses"}, donePulses, 1);
    if (v.expCycles != 0) checkOutput({v.name, " done_cycle"}, doneAt, v.expCycles);
  endtask

  initial begin
    vecs[0] = '{"dump_basic",   1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 34};
    vecs[1] = '{"dump_stall",   1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{"clear_basic",  1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 32};
    vecs[3] = '{"dump_zero",    1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 34};
    vecs[4] = '{"clear_poke",   1'b1, 1, 2, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{"dump_poke",    1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 0};

    rst_n      = 1'b0;
    start      = 1'b0;
    clear_mode = 1'b0;
    abort      = 1'b0;
    port_gnt   = 1'b0;
    dout_ready = 1'b0;
    #12;
    checkOutput("reset dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset rd_reg", 32'(rd_reg), 32'd0);
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-dump while a word is held stalled.
    preload(1);
    @(negedge clk);
    start    = 1'b1;
    port_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("middump valid_before_reset", 32'(dout_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("middump dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("middump dout_data", dout_data, 32'd0);
    checkOutput("middump dout_idx", 32'(dout_idx), 32'd0);
    checkOutput("middump busy", 32'(busy), 32'd0);
    checkOutput("middump done", 32'(done), 32'd0);
    checkOutput("middump rd_reg", 32'(rd_reg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Abort a clear once idx reaches 10: x1..x9 cleared, x10..x31 untouched.
    begin
      int zeroCnt = 0, oneCnt = 0, doneSeen = 0;
      preload(2);
      @(negedge clk);
      start      = 1'b1;
      clear_mode = 1'b1;
      port_gnt   = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      clear_mode = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      #1;
      checkOutput("abort rd_reg", 32'(rd_reg), 32'd10);
      checkOutput("abort wr_en", 32'(wr_en), 32'd0);
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort busy", 32'(busy), 32'd0);
      repeat (4) begin
        if (done) doneSeen++;
        @(negedge clk);
      end
      checkOutput("abort done_pulses", doneSeen, 0);
      for (int r = 1; r < NUM_REGS; r++) begin
        if (r < 10 && mem[r] == '0) zeroCnt++;
        if (r >= 10 && mem[r] == '1) oneCnt++;
      end
      checkOutput("abort zeroed_regs", zeroCnt, 9);
      checkOutput("abort kept_regs", oneCnt, 22);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Debug/verification access engine for the integer register file. On command it either sweeps every architectural register through a register-file read port and streams the contents out over a valid/ready interface, or walks the write port to clear x1..x31 to zero. Sits beside the register file behind the core's debug mux and only touches the file's ports while the core grants them.

## Interface
- NUM_REGS, 32, number of architectural registers (power of two, ≥2)
- ADDR_W, 5, register index width (log2 NUM_REGS)
- DATA_W, 32, register data width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- clear_mode  in  1  sampled with start: 0 = dump, 1 = clear
- abort  in  1  synchronous cancel of any active command
- port_gnt  in  1  core grants the register-file read/write ports this cycle
- rd_reg  out  ADDR_W  register-file read address
- rd_data  in  DATA_W  register-file read data (combinational from rd_reg)
- wr_en  out  1  register-file write enable
- wr_reg  out  ADDR_W  register-file write address
- wr_data  out  DATA_W  register-file write data (always 0)
- dout_valid  out  1  dump word available
- dout_ready  in  1  consumer accepts dump word
- dout_data  out  DATA_W  dumped register value
- dout_idx  out  ADDR_W  index of dumped register
- busy  out  1  command in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, DUMP, CLEAR, DONE. Internal counter idx (ADDR_W bits).
- IDLE: start=1 & clear_mode=0 -> DUMP, idx←0; start=1 & clear_mode=1 -> CLEAR, idx←1. start in any other state ignored.
- rd_reg = idx, wr_reg = idx combinationally; wr_data = 0 always.
- DUMP: output register (dout_data, dout_idx, dout_valid) loads rd_data/idx when port_gnt & (!dout_valid | dout_ready) and not all words issued; idx then increments. Handshake when dout_valid & dout_ready; if no new load same cycle, dout_valid←0. dout_data/dout_idx held stable while dout_valid & !dout_ready.
- DUMP ends on handshake of word with dout_idx = NUM_REGS-1 -> DONE. idx never wraps to re-read x0; "all issued" flag blocks further loads.
- CLEAR: wr_en = port_gnt (combinational, only in CLEAR). Each granted cycle idx increments. Write at idx = NUM_REGS-1 -> DONE. x0 never addressed for write.
- DONE: done=1 for exactly one cycle, then IDLE.
- port_gnt low: no load, no write, idx frozen; pending dout word still drainable.
- abort (any non-IDLE state): next state IDLE, dout_valid←0, wr_en low that cycle, no done pulse. abort takes priority over every other transition.
- rst_n low: immediately state=IDLE, idx=0, dout_valid=0, dout_data=0, dout_idx=0, done=0, busy=0; wr_en=0, rd_reg=0, wr_reg=0 follow.

## Timing
- Dump, port_gnt=1, dout_ready=1: start seen at edge E; word k valid in cycle after edge E+1+k; last word (x31) valid after E+32, handshaked at E+33; done high the cycle after E+33; busy low after E+34. 34 cycles start-to-done.
- Clear, port_gnt=1: wr_en high for 31 cycles after E (x1..x31); done high after E+31.
- Backpressure adds one cycle per stalled dout_ready cycle; grant withdrawal adds one cycle per non-granted cycle.
- dout_valid, dout_data, dout_idx, done, busy are registered; rd_reg, wr_reg, wr_en combinational from state/idx/port_gnt.

## Test plan
- Reset mid-dump: assert rst_n=0 with dout_valid=1 -> all outputs 0 immediately, busy=0; after release, start works normally.
- Dump with regfile preloaded x_i = 0xA5A50000+i, gnt=1, ready=1 -> 32 words, dout_idx 0..31, x0 word = 0, done after 34 cycles.
- Dump with dout_ready toggling 1/0 and port_gnt low every 3rd cycle -> no dropped or duplicated index, data held stable while stalled.
- Clear after filling x1..x31 with 0xFFFFFFFF, gnt=1 -> 31 writes, no write to x0, subsequent dump returns all zeros.
- abort at idx=10 during clear -> x1..x9 (and x10 if granted that cycle excluded) zeroed only, no done, busy low next cycle.
- start asserted while busy and start with clear_mode toggling mid-command -> ignored; command mode fixed at acceptance.
